// File: rtl/sample_packetizer_pkg.sv
// Shared constants and FSM encoding for the serial uplink packetizer.
package sample_packetizer_pkg;

    // Header bytes carry the sync marker in bit 7; data bytes always have bit 7 clear.
    localparam logic        HDR_MARK = 1'b1;
    // Channel index occupies header bits [6:4].
    localparam int unsigned CH_POS   = 4;
    // Width of the per-byte MSB field in header bits [3:0].
    localparam int unsigned M_W      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitHi,
        StWaitLo
    } pkt_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Show-ahead frame FIFO; a push into a full FIFO is accepted only alongside a pop.
module frame_fifo
    import sample_packetizer_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so the difference is the occupancy.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/sample_packetizer.sv
// Frames NCH samples into 7-bit-safe byte packets for the serial transmitter.
module sample_packetizer
    import sample_packetizer_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned NB       = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BUSY_TMO = 7
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic [7:0]                 decim,
    input  logic                       in_valid,
    input  logic [NCH*8*NB-1:0]        in_data,
    output logic [7:0]                 tx_byte,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic                       pkt_active,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                ovf_cnt
);

    localparam int unsigned SW      = 8 * NB;
    localparam int unsigned FW      = NCH * SW;
    localparam int unsigned TW      = $clog2(BUSY_TMO + 1);
    localparam logic [2:0]  LAST_CH = 3'(NCH - 1);
    localparam logic [2:0]  LAST_BI = 3'(NB);

    // Byte bi of channel ch: bi=0 is the header, bi=1..NB are data bytes LSB first.
    function automatic logic [7:0] pick_byte(input logic [FW-1:0] frame,
                                             input logic [2:0]    ch,
                                             input logic [2:0]    bi);
        logic [SW-1:0]  s;
        logic [M_W-1:0] m;
        logic [7:0]     b;
        s = frame[32'(ch)*SW +: SW];
        m = '0;
        for (int k = 0; k < int'(NB); k++) begin
            m[k] = s[8*k+7];
        end
        b = '0;
        if (bi == 3'd0) begin
            b[7]           = HDR_MARK;
            b[CH_POS +: 3] = ch;
            b[M_W-1:0]     = m;
        end else begin
            b = {1'b0, s[8*(32'(bi)-1) +: 7]};
        end
        return b;
    endfunction

    pkt_state_e       state_q, state_d;
    logic [FW-1:0]    frame_q;
    logic [7:0]       tx_byte_q;
    logic [2:0]       ch_q;
    logic [2:0]       bi_q;
    logic             pkt_active_q;
    logic [TW-1:0]    tmo_q;
    logic [7:0]       dec_cnt_q;
    logic [15:0]      ovf_q;

    logic             pop;
    logic             advance;
    logic             finish;
    logic             tmo_inc;
    logic             last_byte;
    logic             accept;
    logic             keep;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_rdata;

    assign accept     = in_valid & enable;
    assign keep       = accept & (dec_cnt_q == 8'd0);
    assign last_byte  = (ch_q == LAST_CH) && (bi_q == LAST_BI);

    assign tx_byte    = tx_byte_q;
    assign tx_send    = (state_q == StSend);
    assign pkt_active = pkt_active_q;
    assign ovf_cnt    = ovf_q;

    frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (keep),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        tmo_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !tx_busy) state_d = StLoad;
            end
            StLoad: begin
                pop     = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                state_d = StWaitHi;
            end
            StWaitHi: begin
                // A transmitter that never raises busy must not stall the packet.
                if (tx_busy || (tmo_q == TW'(BUSY_TMO - 1))) state_d = StWaitLo;
                else                                         tmo_inc = 1'b1;
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    if (last_byte) begin
                        finish  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        advance = 1'b1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Packet datapath: frame holding register, byte sequencing and busy timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_q      <= '0;
            tx_byte_q    <= '0;
            ch_q         <= '0;
            bi_q         <= '0;
            pkt_active_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            tmo_q <= tmo_inc ? tmo_q + 1'b1 : '0;
            if (pop) begin
                frame_q      <= fifo_rdata;
                tx_byte_q    <= pick_byte(fifo_rdata, 3'd0, 3'd0);
                ch_q         <= '0;
                bi_q         <= '0;
                pkt_active_q <= 1'b1;
            end else if (advance) begin
                if (bi_q == LAST_BI) begin
                    ch_q      <= ch_q + 3'd1;
                    bi_q      <= '0;
                    tx_byte_q <= pick_byte(frame_q, ch_q + 3'd1, 3'd0);
                end else begin
                    bi_q      <= bi_q + 3'd1;
                    tx_byte_q <= pick_byte(frame_q, ch_q, bi_q + 3'd1);
                end
            end else if (finish) begin
                pkt_active_q <= 1'b0;
            end
        end
    end

    // Input side: decimation counter and saturating overflow count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_cnt_q <= '0;
            ovf_q     <= '0;
        end else begin
            if (accept) begin
                if (dec_cnt_q == 8'd0) dec_cnt_q <= (decim > 8'd1) ? decim - 8'd1 : 8'd0;
                else                   dec_cnt_q <= dec_cnt_q - 8'd1;
            end
            // A pop in the same cycle frees a slot, so that case is not an overflow.
            if (keep && fifo_full && !pop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer with a frame-level byte-stream model.
module tb_sample_packetizer;

    localparam int unsigned NCH      = 2;
    localparam int unsigned NB       = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned BUSY_TMO = 7;
    localparam int unsigned SW       = 8 * NB;
    localparam int unsigned FW       = NCH * SW;
    localparam int          BPF      = NCH * (NB + 1);

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     enable = 1'b0;
    logic [7:0]               decim = 8'd0;
    logic                     in_valid = 1'b0;
    logic [FW-1:0]            in_data = '0;
    logic [7:0]               tx_byte;
    logic                     tx_send;
    logic                     tx_busy;
    logic                     pkt_active;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [15:0]              ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sends    = 0;
    int busy_mode = 0;   // 0: never busy, 1: busy 10 cycles after each send, 2: always busy
    int busy_left = 0;
    int last_push_cyc = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         send_cyc [$];

    sample_packetizer #(
        .NCH      (NCH),
        .NB       (NB),
        .DEPTH    (DEPTH),
        .BUSY_TMO (BUSY_TMO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .decim      (decim),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .tx_byte    (tx_byte),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .pkt_active (pkt_active),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Serial transmitter model.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                1: begin
                    if (busy_left > 0) begin
                        tx_busy = 1'b1;
                        busy_left--;
                    end else begin
                        tx_busy = 1'b0;
                    end
                    if (tx_send) busy_left = 10;
                end
                2:       tx_busy = 1'b1;
                default: tx_busy = 1'b0;
            endcase
        end
    end

    // Compare every emitted byte against the model stream.
    always @(negedge clk) begin
        if (rstn && tx_send) begin
            sends++;
            got_q.push_back(tx_byte);
            send_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_send", {24'd0, tx_byte}, 32'hFFFF_FFFF);
            else                   check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
        end
    end

    // Packet contents for one frame, computed from the header/data byte rules.
    function automatic void model_frame(input logic [FW-1:0] d);
        logic [31:0] s;
        int          m;
        for (int c = 0; c < int'(NCH); c++) begin
            s = 32'(d >> (c * SW));
            m = 0;
            for (int k = 0; k < int'(NB); k++) m = m | (int'((s >> (8*k + 7)) & 32'd1) << k);
            exp_q.push_back(8'(32'h80 | (c << 4) | m));
            for (int k = 0; k < int'(NB); k++) exp_q.push_back(8'((s >> (8*k)) & 32'h7F));
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_pkt_active", {31'd0, pkt_active}, 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
        exp_q.delete();
        got_q.delete();
        send_cyc.delete();
        sends = 0;
        rstn = 1'b1;
    endtask

    task automatic push_frame(input logic [FW-1:0] d, input bit kept);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        if (kept) model_frame(d);
        last_push_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pkt_active || fifo_level != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_sends(input int target);
        int n = 0;
        while (sends < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_sends_timeout", 32'(n < 5000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    lit [10];
        logic [7:0]    scratch [$];
        logic [FW-1:0] f;
        lit = '{8'h8C, 8'h01, 8'h7F, 8'h00, 8'h01, 8'h9F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        enable = 1'b1;

        // Single frame, pulsed busy; model pinned against hand-computed bytes.
        busy_mode = 1;
        do_reset();
        model_frame({32'hFFFF_FFFF, 32'h8180_7F01});
        scratch = exp_q;
        exp_q.delete();
        for (int i = 0; i < 10; i++) check("model_pin", {24'd0, scratch[i]}, {24'd0, lit[i]});
        push_frame({32'hFFFF_FFFF, 32'h8180_7F01}, 1'b1);
        wait_drain("t1_drain");
        check("t1_sends", 32'(sends), 32'd10);
        check("t1_latency", 32'(send_cyc[0] - last_push_cyc), 32'd3);
        for (int i = 0; i < 10; i++) check("t1_byte_lit", {24'd0, got_q[i]}, {24'd0, lit[i]});
        check("t1_pkt_active", {31'd0, pkt_active}, 32'd0);
        check("t1_exp_empty", 32'(exp_q.size()), 32'd0);

        // Overflow with the transmitter held busy.
        busy_mode = 2;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            f = {32'(32'h1000_0000 + i), 32'(32'h00C0_0080 + (i << 8))};
            push_frame(f, i < 4);
        end
        repeat (5) @(negedge clk);
        check("t2_level", 32'(fifo_level), 32'd4);
        check("t2_ovf", {16'd0, ovf_cnt}, 32'd2);
        check("t2_no_send", 32'(sends), 32'd0);
        busy_mode = 1;
        wait_drain("t2_drain");
        check("t2_sends", 32'(sends), 32'(4 * BPF));
        check("t2_exp_empty", 32'(exp_q.size()), 32'd0);

        // Decimation by 3.
        busy_mode = 1;
        do_reset();
        decim = 8'd3;
        for (int i = 0; i < 9; i++) begin
            f = {32'(32'hA5A5_0000 + (i << 4)), 32'(32'h8000_0000 + i * 32'h0101_0101)};
            push_frame(f, (i % 3) == 0);
        end
        wait_drain("t3_drain");
        check("t3_sends", 32'(sends), 32'(3 * BPF));
        check("t3_ovf", {16'd0, ovf_cnt}, 32'd0);
        check("t3_exp_empty", 32'(exp_q.size()), 32'd0);
        decim = 8'd0;

        // Busy never rises: each byte paced by the timeout.
        busy_mode = 0;
        do_reset();
        push_frame({32'h1234_5678, 32'h9ABC_DEF0}, 1'b1);
        wait_drain("t4_drain");
        check("t4_sends", 32'(sends), 32'd10);
        for (int i = 1; i < send_cyc.size(); i++) begin
            check("t4_spacing", 32'(send_cyc[i] - send_cyc[i-1]), 32'(BUSY_TMO + 2));
        end
        check("t4_exp_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a packet, with a second frame queued.
        busy_mode = 1;
        do_reset();
        push_frame({32'h0F0F_0F0F, 32'hF0F0_F0F0}, 1'b1);
        push_frame({32'h5555_5555, 32'hAAAA_AAAA}, 1'b1);
        wait_sends(3);
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("t5_tx_send", {31'd0, tx_send}, 32'd0);
        check("t5_pkt_active", {31'd0, pkt_active}, 32'd0);
        check("t5_level_rst", 32'(fifo_level), 32'd0);
        check("t5_ovf", {16'd0, ovf_cnt}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        sends = 0;
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_no_residual", 32'(sends), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);

        // enable low while a packet is in flight.
        busy_mode = 1;
        do_reset();
        push_frame({32'h7654_3210, 32'hFEDC_BA98}, 1'b1);
        begin
            int n = 0;
            while (!pkt_active && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t6_start", 32'(n < 100), 32'd1);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_frame(64'(64'hDEAD_BEEF_0000_0000 + i), 1'b0);
        @(negedge clk);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_ovf", {16'd0, ovf_cnt}, 32'd0);
        enable = 1'b1;
        wait_drain("t6_drain");
        check("t6_sends", 32'(sends), 32'd10);
        check("t6_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_packetizer.md
Name: sample_packetizer

Overview:
Generalised serial uplink framer for the SDR receive chain. Captures frames of NCH filtered samples (e.g. I/Q FIR outputs), buffers them in a small frame FIFO, optionally decimates, and streams each frame as 7-bit-safe byte packets to the serial transmitter using a tx_send/tx_busy handshake. Sits between the FIR stage and the serial module; the host decoder syncs on bit 7 of header bytes.

Parameters:
NCH, 2, channels per frame (1..8)
NB, 4, bytes per sample (1..4); sample width SW = 8*NB
DEPTH, 4, frame FIFO depth (power of 2, >=2)
BUSY_TMO, 7, cycles to wait for tx_busy to rise before giving up on it (>=1)

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
enable  in  1  accept frames when high
decim  in  8  keep 1 of every decim frames; 0 and 1 both mean keep all
in_valid  in  1  frame strobe, one cycle
in_data  in  NCH*SW  frame; channel c at bits [c*SW +: SW]
tx_byte  out  8  byte to serial transmitter
tx_send  out  1  one-cycle send strobe
tx_busy  in  1  serial transmitter busy
pkt_active  out  1  high while a packet is being emitted
fifo_level  out  $clog2(DEPTH)+1  frames currently buffered
ovf_cnt  out  16  frames dropped on full FIFO, saturating at 0xFFFF

Behaviour:
- Reset (async, rstn=0): tx_byte=0, tx_send=0, pkt_active=0, fifo_level=0, ovf_cnt=0, decimation counter=0, FSM=IDLE. Reset mid-packet aborts the packet; no further tx_send.
- Decimation: the counter advances only on in_valid&enable. When the counter is 0, the frame is kept and the counter loads max(decim,1)-1. Otherwise the counter decrements and the frame is discarded without being counted as overflow. A new decim value takes effect at the next reload.
- Push: a kept frame is written to the FIFO in the same cycle. If the FIFO is full, the frame is dropped and ovf_cnt increments (saturating). A simultaneous push and pop on a full FIFO is allowed and is not an overflow.
- in_valid with enable=0: ignored completely. A packet already in progress always completes.
- Packet format, per channel c=0..NCH-1 in order:
  - Header byte: {1'b1, c[2:0], m[3:0]}. m[k] = bit 7 of sample byte k for k<NB; m[k] = 0 for k>=NB.
  - Then NB data bytes, byte 0 (LSB) first, each sent as {1'b0, byte[6:0]}.
  - Total NCH*(NB+1) bytes per frame.
- FSM:
  - IDLE: when FIFO is non-empty and tx_busy=0, go to LOAD.
  - LOAD: pop the FIFO, latch the frame into a shift/holding register, set pkt_active=1, register the first header on tx_byte. Go to SEND.
  - SEND: tx_send=1 for exactly one cycle. Go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO when tx_busy=1, or after BUSY_TMO cycles without busy.
  - WAIT_LO: when tx_busy=0, either advance tx_byte and go to SEND, or, if this was the last byte, drop pkt_active and go to IDLE.
- tx_byte is stable from SEND through WAIT_LO.
- Minimum latency from in_valid (empty FIFO, idle tx) to the first tx_send is 3 cycles.
- fifo_level updates the cycle after a push or pop.

Decomposition:
- Shared package: header marker bit, channel-field position, m-field width (4), and the FSM state encoding (IDLE/LOAD/SEND/WAIT_HI/WAIT_LO).
- One sub-module: frame_fifo (parametrised width NCH*SW, depth DEPTH; synchronous push/pop, full/empty/level, async active-low reset).
- Byte sequencing and header generation stay in sample_packetizer.

Test Plan:
- Single frame, NCH=2, NB=4: ch0=0x81807F01, ch1=0xFFFFFFFF; model the serial side as busy 1 cycle after send, lasting 10 cycles. Required bytes: 8C 01 7F 00 01 9F 7F 7F 7F 7F, exactly 10 tx_send pulses, pkt_active low afterwards.
- Overflow: DEPTH=4, tx_busy held 1, 6 kept frames pushed. Required: fifo_level=4, ovf_cnt=2, no tx_send. Then release busy: exactly 4 packets, carrying frames 0..3 in order.
- Decimation: decim=3, 9 frames with distinct values. Required: 3 packets carrying frames 0, 3, 6; ovf_cnt=0.
- Busy timeout: tx_busy tied 0. Each byte is still emitted, with SEND-to-SEND spacing of BUSY_TMO+2 cycles; the packet completes.
- Reset mid-packet: assert rstn=0 after the 3rd byte. Required: all outputs at reset values immediately; after release, no residual bytes and fifo_level=0.
- enable=0 during 3 in_valid pulses while a packet is in flight. Required: the packet completes; fifo_level and ovf_cnt unchanged.
